// File: rtl/mac_package.sv
// Shared types and constants for the MAC loop sequencer: FSM state, the
// per-stream address-generator control word and the registered output flags.
package mac_package;

    localparam int MAC_SEQ_CNT_WIDTH  = 12;
    localparam int MAC_SEQ_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_WAIT_ENG,
        SEQ_FINISHED
    } mac_seq_state_t;

    // Control word broadcast to every address generator.
    typedef struct packed {
        logic load;
        logic step;
    } ctrl_seq_t;

    typedef struct packed {
        logic iter_valid;
        logic engine_start;
        logic busy;
        logic done;
    } flags_seq_t;

endpackage

// File: rtl/mac_seq_addr_gen.sv
// One address stream: loads its base at job start, then advances by the
// latched stride once per completed iteration, wrapping modulo 2^32.
module mac_seq_addr_gen
    import mac_package::*;
(
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  ctrl_seq_t                     ctrl_i,
    input  logic [MAC_SEQ_ADDR_WIDTH-1:0] base_i,
    input  logic [MAC_SEQ_ADDR_WIDTH-1:0] stride_i,
    output logic [MAC_SEQ_ADDR_WIDTH-1:0] addr_o
);

    logic [MAC_SEQ_ADDR_WIDTH-1:0] addr_q;

    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            addr_q <= '0;
        end else if (ctrl_i.load) begin
            addr_q <= base_i;
        end else if (ctrl_i.step) begin
            addr_q <= addr_q + stride_i;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/mac_loop_seq.sv
// Hardwired loop sequencer: issues nb_iter+1 iterations to the streamer,
// starts the engine after each handshake and pulses done_o at job end.
module mac_loop_seq
    import mac_package::*;
#(
    parameter int N_STREAMS = 4,
    parameter int CNT_WIDTH = MAC_SEQ_CNT_WIDTH
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  clear_i,
    input  logic                                  start_i,
    input  logic [CNT_WIDTH-1:0]                  nb_iter_i,
    input  logic [MAC_SEQ_ADDR_WIDTH-1:0]         stride_i,
    input  logic [N_STREAMS-1:0][MAC_SEQ_ADDR_WIDTH-1:0] base_addr_i,
    output logic                                  iter_valid_o,
    input  logic                                  iter_ready_i,
    output logic [N_STREAMS-1:0][MAC_SEQ_ADDR_WIDTH-1:0] addr_o,
    output logic [CNT_WIDTH-1:0]                  iter_idx_o,
    output logic                                  engine_start_o,
    input  logic                                  engine_done_i,
    output logic                                  busy_o,
    output logic                                  done_o
);

    mac_seq_state_t                state_q;
    logic [CNT_WIDTH-1:0]          idx_q;
    logic [CNT_WIDTH-1:0]          nb_iter_q;
    logic [MAC_SEQ_ADDR_WIDTH-1:0] stride_q;
    flags_seq_t                    flags_q;
    ctrl_seq_t                     addr_ctrl;
    logic                          last_iter;

    // Compared before incrementing, so an all-ones count never wraps the index.
    assign last_iter = (idx_q == nb_iter_q);

    // NOTE: defaults assigned first so every path drives addr_ctrl (no latch).
    always_comb begin
        addr_ctrl      = '0;
        addr_ctrl.load = (state_q == SEQ_IDLE) && start_i;
        addr_ctrl.step = (state_q == SEQ_WAIT_ENG) && engine_done_i && !last_iter;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q   <= SEQ_IDLE;
            idx_q     <= '0;
            nb_iter_q <= '0;
            stride_q  <= '0;
            flags_q   <= '0;
        end else begin
            flags_q.engine_start <= 1'b0;
            flags_q.done         <= 1'b0;
            case (state_q)
                SEQ_IDLE: begin
                    if (start_i) begin
                        nb_iter_q          <= nb_iter_i;
                        stride_q           <= stride_i;
                        idx_q              <= '0;
                        state_q            <= SEQ_ISSUE;
                        flags_q.iter_valid <= 1'b1;
                        flags_q.busy       <= 1'b1;
                    end
                end
                SEQ_ISSUE: begin
                    if (iter_ready_i) begin
                        state_q              <= SEQ_WAIT_ENG;
                        flags_q.iter_valid   <= 1'b0;
                        flags_q.engine_start <= 1'b1;
                    end
                end
                SEQ_WAIT_ENG: begin
                    if (engine_done_i) begin
                        if (last_iter) begin
                            state_q      <= SEQ_FINISHED;
                            flags_q.done <= 1'b1;
                        end else begin
                            idx_q              <= idx_q + CNT_WIDTH'(1);
                            state_q            <= SEQ_ISSUE;
                            flags_q.iter_valid <= 1'b1;
                        end
                    end
                end
                SEQ_FINISHED: begin
                    state_q      <= SEQ_IDLE;
                    flags_q.busy <= 1'b0;
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

    for (genvar s = 0; s < N_STREAMS; s++) begin : g_stream
        mac_seq_addr_gen u_addr_gen (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clear_i  (clear_i),
            .ctrl_i   (addr_ctrl),
            .base_i   (base_addr_i[s]),
            .stride_i (stride_q),
            .addr_o   (addr_o[s])
        );
    end

    assign iter_valid_o   = flags_q.iter_valid;
    assign engine_start_o = flags_q.engine_start;
    assign busy_o         = flags_q.busy;
    assign done_o         = flags_q.done;
    assign iter_idx_o     = idx_q;

endmodule

// File: tb/tb_mac_loop_seq.sv
// Bench for mac_loop_seq: a job-level model (address = base + k*stride)
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mac_loop_seq;

    localparam int NS = 4;
    localparam int CW = 12;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   clear = 1'b0;
    logic                   start = 1'b0;
    logic [CW-1:0]          nb_iter = '0;
    logic [31:0]            stride = '0;
    logic [NS-1:0][31:0]    base = '0;
    logic                   ready = 1'b0;
    logic                   eng_done = 1'b0;
    logic                   valid;
    logic [NS-1:0][31:0]    addr;
    logic [CW-1:0]          idx;
    logic                   eng_start;
    logic                   busy;
    logic                   done;

    always #5 clk = ~clk;

    mac_loop_seq #(.N_STREAMS(NS), .CNT_WIDTH(CW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .start_i        (start),
        .nb_iter_i      (nb_iter),
        .stride_i       (stride),
        .base_addr_i    (base),
        .iter_valid_o   (valid),
        .iter_ready_i   (ready),
        .addr_o         (addr),
        .iter_idx_o     (idx),
        .engine_start_o (eng_start),
        .engine_done_i  (eng_done),
        .busy_o         (busy),
        .done_o         (done)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: a job is a sequence of iterations k = 0..last; each one
    // is offered, handshaken, engine started, then completed.
    bit          m_active = 0, m_offer = 0, m_wait = 0, m_fin = 0, m_start_p = 0;
    int unsigned m_k = 0;
    logic [CW-1:0] m_last = '0;
    logic [31:0] m_stride = '0;
    logic [31:0] m_base [NS] = '{default: '0};

    always @(posedge clk) begin
        if (!rst_n || clear) begin
            m_active = 0; m_offer = 0; m_wait = 0; m_fin = 0; m_start_p = 0;
            m_k = 0; m_last = '0; m_stride = '0;
            for (int s = 0; s < NS; s++) m_base[s] = '0;
        end else begin
            m_start_p = 0;
            if (m_fin) begin
                m_fin = 0; m_active = 0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1; m_offer = 1; m_k = 0;
                    m_last = nb_iter; m_stride = stride;
                    for (int s = 0; s < NS; s++) m_base[s] = base[s];
                end
            end else if (m_offer) begin
                if (ready) begin
                    m_offer = 0; m_wait = 1; m_start_p = 1;
                end
            end else if (m_wait && eng_done) begin
                m_wait = 0;
                if (m_k == int'(m_last)) m_fin = 1;
                else begin
                    m_k++; m_offer = 1;
                end
            end
        end
    end

    // Per-cycle compare plus event logging for the directed scenarios.
    bit          cmp_en = 0;
    int          n_starts = 0, n_dones = 0;
    logic [31:0] hs_addr[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [31:0] exp_a;
            check("iter_valid", valid, m_offer);
            check("busy", busy, m_active);
            check("done", done, m_fin);
            check("engine_start", eng_start, m_start_p);
            check("iter_idx", idx, m_k[CW-1:0]);
            for (int s = 0; s < NS; s++) begin
                exp_a = m_base[s] + m_k * m_stride;
                check($sformatf("addr[%0d]", s), addr[s], exp_a);
            end
            if (eng_start) n_starts++;
            if (done) n_dones++;
            if (valid && ready) hs_addr.push_back(addr[0]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        n_starts = 0; n_dones = 0; hs_addr.delete();
    endtask

    task automatic start_job(input logic [CW-1:0] n, input logic [31:0] st, input logic [31:0] b0);
        nb_iter = n; stride = st; base[0] = b0;
        for (int s = 1; s < NS; s++) base[s] = $urandom;
        start = 1'b1;
        cyc();
        start = 1'b0;
        nb_iter = CW'($urandom); stride = $urandom;
        for (int s = 0; s < NS; s++) base[s] = $urandom;
    endtask

    task automatic run_to_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            cyc();
            n++;
        end
        check("job_timeout_busy", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_seq [4];
        logic [31:0] cap_a;
        logic [CW-1:0] cap_i;
        int n;

        cyc();
        cyc();
        cmp_en = 1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_addr0", addr[0], 32'h0);
        check("rst_idx", idx, '0);
        check("rst_done", done, 1'b0);
        rst_n = 1'b1;
        cyc();

        // Four iterations with random handshake timing.
        clr_log();
        exp_seq = '{32'h1000, 32'h1010, 32'h1020, 32'h1030};
        start_job(CW'(3), 32'h10, 32'h1000);
        n = 0;
        while (busy && n < 300) begin
            ready = 1'($urandom);
            eng_done = 1'($urandom);
            cyc();
            n++;
        end
        check("A_timeout_busy", busy, 1'b0);
        check("A_starts", n_starts, 4);
        check("A_dones", n_dones, 1);
        check("A_hs_count", hs_addr.size(), 4);
        for (int i = 0; i < 4 && i < hs_addr.size(); i++)
            check($sformatf("A_hs_addr%0d", i), hs_addr[i], exp_seq[i]);

        // Single iteration, engine done in the same cycle as its start.
        clr_log();
        ready = 1'b1; eng_done = 1'b1;
        start_job(CW'(0), 32'h4, 32'h200);
        run_to_idle(20);
        check("B_starts", n_starts, 1);
        check("B_dones", n_dones, 1);
        check("B_hs_count", hs_addr.size(), 1);

        // Back-pressure: valid/address/index held while ready stays low.
        clr_log();
        ready = 1'b0; eng_done = 1'b0;
        start_job(CW'(2), 32'h8, 32'h3000);
        cap_a = addr[0]; cap_i = idx;
        check("C_valid0", valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("C_valid_hold", valid, 1'b1);
            check("C_addr_hold", addr[0], cap_a);
            check("C_idx_hold", idx, cap_i);
            check("C_no_engine_start", eng_start, 1'b0);
        end
        ready = 1'b1; eng_done = 1'b1;
        run_to_idle(40);

        // Address wraps modulo 2^32.
        clr_log();
        start_job(CW'(1), 32'h20, 32'hFFFF_FFF0);
        run_to_idle(40);
        check("D_hs_count", hs_addr.size(), 2);
        if (hs_addr.size() == 2) check("D_wrap_addr", hs_addr[1], 32'h0000_0010);

        // Clear in WAIT_ENG of iteration 2 together with start.
        clr_log();
        ready = 1'b1; eng_done = 1'b0;
        start_job(CW'(3), 32'h40, 32'h5000);
        n = 0;
        while (!(busy && !valid && idx == CW'(1)) && n < 50) begin
            eng_done = (n % 3 == 1);
            cyc();
            n++;
            eng_done = 1'b0;
        end
        check("E_reached_wait", idx, CW'(1));
        clear = 1'b1; start = 1'b1;
        cyc();
        clear = 1'b0; start = 1'b0;
        check("E_busy_after_clear", busy, 1'b0);
        check("E_valid_after_clear", valid, 1'b0);
        for (int i = 0; i < 3; i++) cyc();
        check("E_still_idle", busy, 1'b0);
        check("E_no_done", n_dones, 0);

        // Start and engine_done while issuing are ignored.
        clr_log();
        ready = 1'b0; eng_done = 1'b0;
        start_job(CW'(1), 32'h100, 32'h7000);
        cap_a = addr[0]; cap_i = idx;
        start = 1'b1; eng_done = 1'b1;
        nb_iter = '1; stride = 32'h5; base[0] = 32'h9999;
        cyc();
        cyc();
        start = 1'b0;
        check("F_addr_same", addr[0], cap_a);
        check("F_idx_same", idx, cap_i);
        check("F_valid_same", valid, 1'b1);
        ready = 1'b1;
        run_to_idle(40);
        check("F_hs_count", hs_addr.size(), 2);
        if (hs_addr.size() == 2) check("F_second_addr", hs_addr[1], 32'h7100);

        // Random traffic including stray starts, clears and resets.
        for (int c = 0; c < 4000; c++) begin
            start = ($urandom % 6 == 0);
            clear = ($urandom % 250 == 0);
            rst_n = ($urandom % 400 != 0);
            ready = 1'($urandom);
            eng_done = ($urandom % 3 == 0);
            nb_iter = CW'($urandom_range(0, 4));
            stride = $urandom;
            for (int s = 0; s < NS; s++) base[s] = $urandom;
            cyc();
        end
        start = 1'b0; clear = 1'b0; rst_n = 1'b1;
        ready = 1'b1; eng_done = 1'b1;
        run_to_idle(40);

        // Full-range count: all-ones gives 2^CW iterations, no index wrap.
        clr_log();
        start_job('1, 32'h4, 32'h0);
        while (busy && n_dones == 0 && hs_addr.size() < 5000) cyc();
        check("H_last_idx", idx, 12'hFFF);
        check("H_last_addr", addr[0], 32'h0000_3FFC);
        run_to_idle(10);
        check("H_starts", n_starts, 4096);
        check("H_dones", n_dones, 1);
        check("H_hs_count", hs_addr.size(), 4096);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
